// File: rtl/debounce_pkg.sv
// Shared defaults and sizing helper for the multi-channel button debouncer.
package debounce_pkg;

    localparam int DEF_N_CH            = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 8;
    localparam bit DEF_INIT_LEVEL      = 1'b0;

    // Counter must hold 0..cycles without wrapping.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One debounce channel: synchronizer chain, disagreement counter, accepted level
// and registered edge pulses.
module button_debounce_ch
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit INIT_LEVEL      = DEF_INIT_LEVEL
) (
    input  logic clk,
    input  logic rst,
    input  logic a_in,
    output logic s,
    output logic rise,
    output logic fall,
    output logic rise_nxt
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        sync_d  = {sync_q[SYNC_STAGES-2:0], a_in};
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_out != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_out;
                rise_d  = sync_out;
                fall_d  = ~sync_out;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: state uses non-blocking assignments; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
            cnt_q   <= '0;
            level_q <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign s        = level_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign rise_nxt = rise_d;

endmodule

// File: rtl/button_debounce_multi.sv
// N_CH independent debounce channels plus a registered any-rise summary that
// lines up with the per-channel rise pulses.
module button_debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH            = DEF_N_CH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit INIT_LEVEL      = DEF_INIT_LEVEL
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] a,
    output logic [N_CH-1:0] s,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            any_rise
);

    logic [N_CH-1:0] rise_nxt;
    logic            any_rise_q, any_rise_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INIT_LEVEL     (INIT_LEVEL)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .a_in    (a[i]),
            .s       (s[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .rise_nxt(rise_nxt[i])
        );
    end

    // Reduce the next-state rise bits so any_rise is registered in the same cycle as rise.
    always_comb begin
        any_rise_d = |rise_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            any_rise_q <= 1'b0;
        end else begin
            any_rise_q <= any_rise_d;
        end
    end

    assign any_rise = any_rise_q;

endmodule
